// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the message-to-polynomial FSM state encoding.
package kyber_pkg;

  localparam int KYBER_Q      = 3329;
  localparam int KYBER_HALF_Q = 1665;
  localparam int KYBER_N      = 256;
  localparam int MSG_BYTES    = 32;

  // Message expansion FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } from_msg_state_e;

  // Increment a byte address, holding at the last valid byte
  function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
    logic [4:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + 5'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/enc_from_msg.sv
// enc_from_msg: expands a 32-byte message into 256 polynomial coefficients,
// one per cycle, LSB-first per byte. A '1' bit becomes HALF_Q, a '0' bit 0.
// The message RAM is synchronous: data follows the read address by one cycle,
// so the next byte address is issued 8 cycles ahead of when it is consumed.
// Run length is fixed at N_COEF writes regardless of message contents.
// Optional macro FROM_MSG_OUT_REG_EN adds one register stage on the write
// strobe/address/data and done (busy stretches one cycle to cover it).
module enc_from_msg
  import kyber_pkg::*;
#(
  parameter int HALF_Q = KYBER_HALF_Q,
  parameter int N_COEF = KYBER_N
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  msg_RAd,
  input  logic [7:0]  msg_RData,
  output logic        P8_out_ready,
  output logic [7:0]  P8_Poly_WAd,
  output logic [11:0] P8_WData,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0]  LAST_ADDR = 8'(N_COEF - 1);
  localparam logic [4:0]  LAST_BYTE = 5'(N_COEF / 8 - 1);
  localparam logic [11:0] ONE_VAL   = 12'(HALF_Q);

  // Coefficient value for one message bit
  function automatic logic [11:0] coef_val(input logic b);
    logic [11:0] v;
    if (b) begin
      v = ONE_VAL;
    end else begin
      v = 12'd0;
    end
    return v;
  endfunction

  from_msg_state_e state_r, state_s;
  logic [7:0]  shreg_r, shreg_s;     // bits of the current byte not yet emitted
  logic [7:0]  cnt_r, cnt_s;         // address of the coefficient on the outputs
  logic [7:0]  next_addr_s;
  logic [4:0]  rad_r, rad_s;
  logic        out_ready_r, out_ready_s;
  logic [7:0]  wad_r, wad_s;
  logic [11:0] wdata_r, wdata_s;
  logic        done_r, done_s;
  logic        busy_r, busy_s;

  // Next-state and next-output decode; outputs are computed one cycle ahead
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    cnt_s       = cnt_r;
    rad_s       = rad_r;
    out_ready_s = 1'b0;
    wad_s       = 8'd0;
    wdata_s     = 12'd0;
    done_s      = 1'b0;
    next_addr_s = cnt_r + 8'd1;

    case (state_r)
      ST_IDLE: begin
        rad_s = 5'd0;
        if (start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // byte 0 is on msg_RData now; emit its bit 0 and keep the rest
        shreg_s     = {1'b0, msg_RData[7:1]};
        rad_s       = sat_inc(5'd0, LAST_BYTE);
        cnt_s       = 8'd0;
        out_ready_s = 1'b1;
        wad_s       = 8'd0;
        wdata_s     = coef_val(msg_RData[0]);
        state_s     = ST_EXPAND;
      end

      ST_EXPAND: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          rad_s   = 5'd0;
        end else begin
          cnt_s       = next_addr_s;
          out_ready_s = 1'b1;
          wad_s       = next_addr_s;
          if (cnt_r[2:0] == 3'd7) begin
            // byte boundary: take the next byte straight from the RAM
            wdata_s = coef_val(msg_RData[0]);
            shreg_s = {1'b0, msg_RData[7:1]};
            rad_s   = sat_inc(rad_r, LAST_BYTE);
          end else begin
            wdata_s = coef_val(shreg_r[0]);
            shreg_s = {1'b0, shreg_r[7:1]};
          end
        end
      end

      ST_DONE: begin
        rad_s   = 5'd0;
        shreg_s = 8'd0;
        cnt_s   = 8'd0;
        state_s = ST_IDLE;
      end

      default: begin
        rad_s   = 5'd0;
        shreg_s = 8'd0;
        cnt_s   = 8'd0;
        state_s = ST_IDLE;
      end
    endcase

`ifdef FROM_MSG_OUT_REG_EN
    busy_s = (state_s != ST_IDLE) || (state_r == ST_DONE);
`else
    busy_s = (state_s != ST_IDLE);
`endif
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shreg_r     <= 8'd0;
      cnt_r       <= 8'd0;
      rad_r       <= 5'd0;
      out_ready_r <= 1'b0;
      wad_r       <= 8'd0;
      wdata_r     <= 12'd0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      cnt_r       <= cnt_s;
      rad_r       <= rad_s;
      out_ready_r <= out_ready_s;
      wad_r       <= wad_s;
      wdata_r     <= wdata_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
    end
  end

  assign msg_RAd = rad_r;
  assign busy    = busy_r;

`ifdef FROM_MSG_OUT_REG_EN
  logic        out_ready_q_r;
  logic [7:0]  wad_q_r;
  logic [11:0] wdata_q_r;
  logic        done_q_r;

  // Extra output stage toward the k-memory write mux
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ready_q_r <= 1'b0;
      wad_q_r       <= 8'd0;
      wdata_q_r     <= 12'd0;
      done_q_r      <= 1'b0;
    end else begin
      out_ready_q_r <= out_ready_r;
      wad_q_r       <= wad_r;
      wdata_q_r     <= wdata_r;
      done_q_r      <= done_r;
    end
  end

  assign P8_out_ready = out_ready_q_r;
  assign P8_Poly_WAd  = wad_q_r;
  assign P8_WData     = wdata_q_r;
  assign done         = done_q_r;
`else
  assign P8_out_ready = out_ready_r;
  assign P8_Poly_WAd  = wad_r;
  assign P8_WData     = wdata_r;
  assign done         = done_r;
`endif

endmodule

// File: tb/tb_enc_from_msg.sv
// Directed bench for enc_from_msg with a synchronous message RAM model.
// Cycle n is the clock period following edge n-1; start is sampled at edge 0.
module tb_enc_from_msg;

`ifdef FROM_MSG_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int FIRST_WR  = 2 + LAT;
  localparam int DONE_C    = 258 + LAT;
  localparam int BUSY_LAST = 258 + LAT;
  localparam int HALF      = 1665;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  msg_RAd;
  logic [7:0]  msg_RData;
  logic        P8_out_ready;
  logic [7:0]  P8_Poly_WAd;
  logic [11:0] P8_WData;
  logic        busy;
  logic        done;

  logic [7:0] msg_mem [0:31];

  int checks = 0;
  int errors = 0;

  int wr_addr [0:511];
  int wr_data [0:511];
  int wr_cyc  [0:511];
  int n_wr, n_done, done_cyc, busy_first, busy_last, busy_n, idle_nz;

  int exp_ones [0:5] = '{0, 1, 1, 256, 128, 80};

  enc_from_msg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .msg_RAd      (msg_RAd),
    .msg_RData    (msg_RData),
    .P8_out_ready (P8_out_ready),
    .P8_Poly_WAd  (P8_Poly_WAd),
    .P8_WData     (P8_WData),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // synchronous message RAM
  always @(posedge clk) msg_RData <= msg_mem[msg_RAd];

  task automatic fill(input int kind);
    for (int b = 0; b < 32; b++) begin
      case (kind)
        0: msg_mem[b] = 8'h00;
        1: msg_mem[b] = (b == 0) ? 8'h01 : 8'h00;
        2: msg_mem[b] = (b == 31) ? 8'h80 : 8'h00;
        3: msg_mem[b] = 8'hFF;
        4: msg_mem[b] = 8'hA5;
        default: msg_mem[b] = 8'(b);
      endcase
    end
  endtask

  // Raise start for edge 0, then record ncyc cycles of outputs (no checking)
  task automatic capture(input int ncyc, input bit hold, input int rst_cyc, input int pulse_cyc);
    n_wr = 0; n_done = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
    busy_n = 0; idle_nz = 0;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      #1;
      start = hold || (n == pulse_cyc);
      rst_n = (n == rst_cyc) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (P8_out_ready === 1'b1) begin
        if (n_wr < 512) begin
          wr_addr[n_wr] = int'(P8_Poly_WAd);
          wr_data[n_wr] = int'(P8_WData);
          wr_cyc[n_wr]  = n;
        end
        n_wr++;
      end else if (P8_Poly_WAd !== 8'd0 || P8_WData !== 12'd0) begin
        idle_nz++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (busy === 1'b1) begin
        if (busy_first < 0) busy_first = n;
        busy_last = n;
        busy_n++;
      end
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fill(0);
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (msg_RAd !== 5'd0) begin errors++; $display("FAIL reset_rad got %0d want 0", msg_RAd); end
    checks++; if (P8_out_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", P8_out_ready); end
    checks++; if (P8_Poly_WAd !== 8'd0) begin errors++; $display("FAIL reset_wad got %0d want 0", P8_Poly_WAd); end
    checks++; if (P8_WData !== 12'd0) begin errors++; $display("FAIL reset_wdata got %0d want 0", P8_WData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_messages();
    for (int k = 0; k < 6; k++) begin
      int ones;
      fill(k);
      capture(265, 1'b0, 0, 0);
      checks++; if (n_wr !== 256) begin errors++; $display("FAIL msg%0d_nwr got %0d want 256", k, n_wr); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL msg%0d_ndone got %0d want 1", k, n_done); end
      checks++; if (done_cyc !== DONE_C) begin errors++; $display("FAIL msg%0d_donecyc got %0d want %0d", k, done_cyc, DONE_C); end
      checks++; if (busy_first !== 1 || busy_last !== BUSY_LAST || busy_n !== BUSY_LAST) begin
        errors++; $display("FAIL msg%0d_busy got %0d..%0d (%0d) want 1..%0d", k, busy_first, busy_last, busy_n, BUSY_LAST);
      end
      checks++; if (idle_nz !== 0) begin errors++; $display("FAIL msg%0d_idle_zero got %0d nonzero cycles want 0", k, idle_nz); end
      checks++; if (msg_RAd !== 5'd0) begin errors++; $display("FAIL msg%0d_idle_rad got %0d want 0", k, msg_RAd); end
      ones = 0;
      for (int i = 0; i < 256 && i < n_wr; i++) begin
        logic [7:0] bv;
        int ev;
        bv = msg_mem[i / 8];
        ev = bv[i % 8] ? HALF : 0;
        if (wr_data[i] == HALF) ones++;
        checks++;
        if (wr_addr[i] !== i || wr_cyc[i] !== FIRST_WR + i || wr_data[i] !== ev) begin
          errors++;
          $display("FAIL msg%0d_wr%0d got addr %0d cyc %0d data %0d want addr %0d cyc %0d data %0d",
                   k, i, wr_addr[i], wr_cyc[i], wr_data[i], i, FIRST_WR + i, ev);
        end
      end
      checks++; if (ones !== exp_ones[k]) begin errors++; $display("FAIL msg%0d_ones got %0d want %0d", k, ones, exp_ones[k]); end
    end
  endtask

  task automatic test_start_ignored();
    int pulses [0:1] = '{50, 258};
    fill(4);
    for (int p = 0; p < 2; p++) begin
      capture(270, 1'b0, 0, pulses[p]);
      checks++; if (n_wr !== 256) begin errors++; $display("FAIL ign%0d_nwr got %0d want 256", pulses[p], n_wr); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL ign%0d_ndone got %0d want 1", pulses[p], n_done); end
      checks++; if (busy_last !== BUSY_LAST) begin errors++; $display("FAIL ign%0d_busylast got %0d want %0d", pulses[p], busy_last, BUSY_LAST); end
    end
  endtask

  task automatic test_start_held();
    int n1;
    fill(4);
    capture(280, 1'b1, 0, 0);
    n1 = 0;
    for (int i = 0; i < n_wr && i < 512; i++) if (wr_cyc[i] <= DONE_C) n1++;
    checks++; if (n1 !== 256) begin errors++; $display("FAIL held_first_run_nwr got %0d want 256", n1); end
    checks++; if (n_done !== 1 || done_cyc !== DONE_C) begin errors++; $display("FAIL held_done got %0d at %0d want 1 at %0d", n_done, done_cyc, DONE_C); end
    checks++;
    if (n_wr <= 256 || wr_cyc[256] !== 261 + LAT || wr_addr[256] !== 0 || wr_data[256] !== HALF) begin
      errors++;
      $display("FAIL held_restart got nwr %0d cyc %0d addr %0d data %0d want cyc %0d addr 0 data %0d",
               n_wr, wr_cyc[256], wr_addr[256], wr_data[256], 261 + LAT, HALF);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    fill(5);
    capture(270, 1'b0, 100, 0);
    checks++; if (n_wr !== 99 - LAT) begin errors++; $display("FAIL rstmid_nwr got %0d want %0d", n_wr, 99 - LAT); end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rstmid_ndone got %0d want 0", n_done); end
    checks++; if (busy_last !== 100) begin errors++; $display("FAIL rstmid_busylast got %0d want 100", busy_last); end
    checks++; if (idle_nz !== 0) begin errors++; $display("FAIL rstmid_idle_zero got %0d want 0", idle_nz); end
    // a fresh start afterwards runs to completion
    capture(265, 1'b0, 0, 0);
    checks++; if (n_wr !== 256) begin errors++; $display("FAIL rerun_nwr got %0d want 256", n_wr); end
    checks++; if (done_cyc !== DONE_C || n_done !== 1) begin errors++; $display("FAIL rerun_done got %0d at %0d want 1 at %0d", n_done, done_cyc, DONE_C); end
    for (int i = 0; i < 256 && i < n_wr; i++) begin
      logic [7:0] bv;
      int ev;
      bv = msg_mem[i / 8];
      ev = bv[i % 8] ? HALF : 0;
      checks++;
      if (wr_addr[i] !== i || wr_data[i] !== ev) begin
        errors++;
        $display("FAIL rerun_wr%0d got addr %0d data %0d want addr %0d data %0d", i, wr_addr[i], wr_data[i], i, ev);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_messages();
    test_start_ignored();
    test_start_held();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_from_msg.md
ENC_FROM_MSG -- requirements
Module: enc_from_msg

Interface
REQ-001 SHALL have parameter HALF_Q, default 1665, value written for a '1' message bit (round(q/2), q=3329).
REQ-002 SHALL have parameter N_COEF, default 256, number of coefficients produced; the message is N_COEF/8 bytes.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  begin conversion; sampled only in IDLE.
REQ-006 SHALL have port msg_RAd  output  5  message byte read address to the message RAM.
REQ-007 SHALL have port msg_RData  input  8  message byte; valid one cycle after msg_RAd is presented (synchronous RAM).
REQ-008 SHALL have port P8_out_ready  output  1  coefficient write strobe toward the k-memory write mux.
REQ-009 SHALL have port P8_Poly_WAd  output  8  coefficient write address.
REQ-010 SHALL have port P8_WData  output  12  coefficient value.
REQ-011 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last write.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, EXPAND, DONE.
REQ-014 IDLE: msg_RAd=0; start=1 -> FETCH; otherwise stay.
REQ-015 FETCH (1 cycle): load msg_RData (byte 0) into the shift register, set msg_RAd=1, clear the coefficient counter -> EXPAND.
REQ-016 EXPAND: each cycle SHALL emit one coefficient: P8_out_ready=1, P8_Poly_WAd=counter, P8_WData=HALF_Q if current bit=1 else 0; the shift register moves right one bit.
REQ-017 Coefficient 8*i+j SHALL equal bit j (LSB first) of message byte i.
REQ-018 At bit index 7 of byte i (i<31): load msg_RData (byte i+1, address held for 8 cycles) into the shift register, and set msg_RAd=i+2 (saturate at 31).
REQ-019 After the write with P8_Poly_WAd=255 -> DONE; DONE asserts done=1 for one cycle -> IDLE.
REQ-020 Timing with start sampled at edge 0: FETCH in cycle 1, writes in cycles 2..257 (addresses 0..255, no gaps), done in cycle 258, busy in cycles 1..258.
REQ-021 When P8_out_ready=0, P8_Poly_WAd and P8_WData SHALL be 0.
REQ-022 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-023 Timing SHALL be independent of message contents (constant time).
REQ-024 The address counter SHALL be 8 bits and SHALL NOT wrap during a run; 256 writes exactly per start.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE and clear the shift register and counters; msg_RAd=0, P8_out_ready=0, P8_Poly_WAd=0, P8_WData=0, busy=0, done=0.
REQ-026 Reset mid-EXPAND SHALL take effect at that edge; no further writes and no done pulse.

Configuration
REQ-027 Macro FROM_MSG_OUT_REG_EN defined: P8_out_ready, P8_Poly_WAd, P8_WData and done SHALL pass through one extra register stage (writes in cycles 3..258, done in cycle 259; busy also extends to cycle 259). The extra stage SHALL be cleared by reset.
REQ-028 Macro FROM_MSG_OUT_REG_EN undefined: timing SHALL be as in REQ-020.

Structure
REQ-029 Shared package kyber_pkg SHALL hold KYBER_Q=3329, KYBER_HALF_Q=1665, KYBER_N=256, MSG_BYTES=32, and the FSM state encoding.
REQ-030 SHALL be a single module; no sub-module.

Verification
REQ-031 All-zero message, start at edge 0 -> 256 writes in cycles 2..257, addresses 0..255 in order, all data 0; done only in cycle 258.
REQ-032 Byte0=0x01, rest 0x00 -> address 0 data 1665, addresses 1..255 data 0.
REQ-033 Byte31=0x80, rest 0x00 -> only address 255 data 1665; all-0xFF message -> all 256 data 1665.
REQ-034 start held high through a run -> exactly 256 writes and one done, then a new run starts from IDLE.
REQ-035 rst_n low in cycle 100 -> P8_out_ready=0 and busy=0 from the next cycle; no done; a new start gives a full, correct run.
REQ-036 FROM_MSG_OUT_REG_EN defined -> identical data and address sequence shifted by +1 cycle; done in cycle 259.
